char_buf_writer_16x16: RTL and testbench

Writable 16x16 character buffer that turns a stream of 8-bit character codes into screen contents for the text-rectangle path. A producer (keyboard/UART decoder, game logic) pushes characters through a valid/ready handshake. The block places them at a hardware cursor and handles newline, backspace, wrap and clear. The display side reads the buffer through the same `char_xy` → `char_code` port the rect_char pipeline already uses for its fixed-text ROM, so it can replace that ROM in place.

---
 rtl/char_buf_writer_16x16.sv | 120 ++++++++++++
 tb/tb_char_buf_writer_16x16.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buf_writer_16x16.sv
// Writable 16x16 character buffer. A valid/ready producer stream is placed at a
// hardware cursor (newline, backspace, wrap, clear); the display reads the
// buffer through a registered char_xy -> char_code port with one-cycle latency.
module char_buf_writer_16x16 #(
    parameter int unsigned HOR_CHAR_NUMBER = 16,
    parameter int unsigned VER_CHAR_NUMBER = 16,
    parameter logic [6:0]  FILL_CHAR       = 7'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic [7:0] wr_char,
    output logic       wr_ready,
    input  logic       clear,
    output logic       busy,
    output logic [7:0] cursor_xy,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code
);

    localparam int unsigned Depth = HOR_CHAR_NUMBER * VER_CHAR_NUMBER;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e     state_q, state_d;
    logic [7:0] sweep_q, sweep_d;
    logic [7:0] cursor_q, cursor_d;
    logic [6:0] char_code_q;

    logic       we;
    logic [7:0] waddr;
    logic [6:0] wdata;

    logic [6:0] mem [Depth];

    // Next-state, handshake and single write-port arbitration.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        cursor_d = cursor_q;
        we       = 1'b0;
        waddr    = cursor_q;
        wdata    = FILL_CHAR;
        wr_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            StClear: begin
                // clear is ignored here so a sweep never restarts.
                busy    = 1'b1;
                we      = 1'b1;
                waddr   = sweep_q;
                sweep_d = sweep_q + 8'd1;
                if (sweep_q == 8'hFF) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                wr_ready = ~clear;
                if (clear) begin
                    state_d  = StClear;
                    sweep_d  = 8'd0;
                    cursor_d = 8'd0;
                end else if (wr_valid) begin
                    if (wr_char >= 8'h20 && wr_char <= 8'h7E) begin
                        // Address is {y, x}; the 8-bit increment carries x into y
                        // and wraps (15,15) back to (0,0).
                        we       = 1'b1;
                        wdata    = wr_char[6:0];
                        cursor_d = cursor_q + 8'd1;
                    end else if (wr_char == 8'h0A || wr_char == 8'h0D) begin
                        cursor_d = {cursor_q[7:4] + 4'd1, 4'd0};
                    end else if (wr_char == 8'h08) begin
                        if (cursor_q != 8'd0) begin
                            we       = 1'b1;
                            waddr    = cursor_q - 8'd1;
                            cursor_d = cursor_q - 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = StClear;
                sweep_d = 8'd0;
            end
        endcase
    end

    // FSM, sweep counter and cursor registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StClear;
            sweep_q  <= 8'd0;
            cursor_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            cursor_q <= cursor_d;
        end
    end

    // Character RAM write port; contents are rebuilt by the sweep after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; read-first on a same-address write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_code_q <= 7'h00;
        end else begin
            char_code_q <= mem[char_xy];
        end
    end

    assign cursor_xy = cursor_q;
    assign char_code = char_code_q;

endmodule

// File: tb/tb_char_buf_writer_16x16.sv
// Self-checking bench for char_buf_writer_16x16 using a read scoreboard queue.
module tb_char_buf_writer_16x16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_char = 8'h00;
    logic       clear = 1'b0;
    logic [7:0] char_xy = 8'h00;
    logic       wr_ready;
    logic       busy;
    logic [7:0] cursor_xy;
    logic [6:0] char_code;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int w;
    int cnt;

    logic [6:0] exp_q[$];
    logic [6:0] m_mem[256];
    logic [7:0] m_cur;

    char_buf_writer_16x16 dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_char   (wr_char),
        .wr_ready  (wr_ready),
        .clear     (clear),
        .busy      (busy),
        .cursor_xy (cursor_xy),
        .char_xy   (char_xy),
        .char_code (char_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_mem[i] = 7'h20;
        m_cur = 8'h00;
    endtask

    task automatic model_apply(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            m_mem[m_cur] = c[6:0];
            m_cur = m_cur + 8'd1;
        end else if (c == 8'h0A || c == 8'h0D) begin
            m_cur = {m_cur[7:4] + 4'd1, 4'd0};
        end else if (c == 8'h08 && m_cur != 8'h00) begin
            m_cur = m_cur - 8'd1;
            m_mem[m_cur] = 7'h20;
        end
    endtask

    task automatic read_expect(input logic [7:0] a, input logic [6:0] e);
        logic [6:0] x;
        char_xy = a;
        exp_q.push_back(e);
        tick();
        x = exp_q.pop_front();
        check($sformatf("rd_%02h", a), char_code, x);
    endtask

    task automatic send(input logic [7:0] c, output int waits);
        waits = 0;
        wr_valid = 1'b1;
        wr_char = c;
        while (!wr_ready && waits < 600) begin
            tick();
            waits++;
        end
        if (!wr_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            tick();
            model_apply(c);
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 600) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_busy", busy, 1);
        check("rst_ready", wr_ready, 0);
        check("rst_cursor", cursor_xy, 8'h00);
        check("rst_code", char_code, 7'h00);
        rst = 1'b0;
        wait_idle(cyc);
        check("boot_sweep", cyc, 256);
        check("boot_ready", wr_ready, 1);
        check("boot_cursor", cursor_xy, 8'h00);
        model_clear();
        for (int a = 0; a < 256; a++) read_expect(8'(a), 7'h20);

        // "AB" back-to-back
        send(8'h41, w);
        send(8'h42, w);
        check("ab_cursor", cursor_xy, 8'h02);
        read_expect(8'h00, 7'h41);
        read_expect(8'h01, 7'h42);

        // 17 x then newline
        pulse_clear();
        check("clr_busy", busy, 1);
        check("clr_cursor", cursor_xy, 8'h00);
        wait_idle(cyc);
        check("clr_sweep", cyc, 256);
        model_clear();
        for (int i = 0; i < 17; i++) send(8'h78, w);
        check("x17_cursor", cursor_xy, 8'h11);
        send(8'h0A, w);
        check("nl_cursor", cursor_xy, 8'h20);
        for (int x = 0; x < 16; x++) read_expect(8'(x), 7'h78);
        read_expect(8'h10, 7'h78);
        read_expect(8'h11, 7'h20);

        // Wrap and backspace
        pulse_clear();
        wait_idle(cyc);
        model_clear();
        for (int i = 0; i < 256; i++) send(8'h61, w);
        check("wrap_cursor", cursor_xy, 8'h00);
        send(8'h08, w);
        check("bs00_cursor", cursor_xy, 8'h00);
        read_expect(8'h00, 7'h61);
        send(8'h62, w);
        send(8'h08, w);
        check("bs_b_cursor", cursor_xy, 8'h00);
        read_expect(8'h00, 7'h20);
        for (int i = 0; i < 16; i++) send(8'h63, w);
        check("row1_cursor", cursor_xy, 8'h10);
        send(8'h08, w);
        check("bs_row_cursor", cursor_xy, 8'h0F);
        read_expect(8'h0F, 7'h20);
        read_expect(8'h0E, 7'h63);

        // clear together with a held 'Z'
        clear = 1'b1;
        wr_valid = 1'b1;
        wr_char = 8'h5A;
        #1;
        check("clrz_ready", wr_ready, 0);
        tick();
        clear = 1'b0;
        check("clrz_busy", busy, 1);
        check("clrz_cursor", cursor_xy, 8'h00);
        model_clear();
        send(8'h5A, w);
        check("clrz_wait", w, 256);
        check("clrz_cursor2", cursor_xy, 8'h01);
        read_expect(8'h00, 7'h5A);

        // Reset during operation, then mid-sweep
        rst = 1'b1;
        #1;
        check("rst_op_cursor", cursor_xy, 8'h00);
        check("rst_op_busy", busy, 1);
        tick();
        rst = 1'b0;
        wait_idle(cyc);
        check("rst_op_sweep", cyc, 256);
        pulse_clear();
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_idle(cyc);
        check("rst_mid_sweep", cyc, 256);
        model_clear();

        // clear during CLEAR does not extend the sweep
        pulse_clear();
        cnt = 0;
        repeat (50) begin
            tick();
            cnt++;
        end
        clear = 1'b1;
        tick();
        cnt++;
        clear = 1'b0;
        wait_idle(cyc);
        check("clr_in_clr", cnt + cyc, 256);
        model_clear();

        // Same-address read and write: old data returned
        char_xy = 8'h00;
        exp_q.push_back(7'h20);
        wr_valid = 1'b1;
        wr_char = 8'h51;
        tick();
        wr_valid = 1'b0;
        check("rw_old", char_code, exp_q.pop_front());
        model_apply(8'h51);
        read_expect(8'h00, 7'h51);
        check("rw_cursor", cursor_xy, 8'h01);

        // Non-printables are dropped
        send(8'h7F, w);
        send(8'hC1, w);
        check("drop_cursor", cursor_xy, 8'h01);
        read_expect(8'h01, 7'h20);

        // Whole screen against the model
        for (int a = 0; a < 256; a++) read_expect(8'(a), m_mem[a]);
        check("model_cursor", cursor_xy, m_cur);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
